// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address/instruction widths, NOP encoding,
// fetch FSM states and a saturating counter helper.
package cpu_pkg;

  localparam int unsigned AddrWidth  = 8;
  localparam int unsigned InstrWidth = 32;

  localparam logic [InstrWidth-1:0] NopInstr = 32'h0;

  typedef enum logic {
    StBoot,
    StRun
  } fetch_state_e;

  // Add a small increment to a 16-bit event counter, sticking at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [2:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {14'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue between the fetch pipeline and decode.
// Entry 0 is always the head, so head outputs come straight from registers.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [InstrWidth-1:0] push_instr,
  input  logic [AddrWidth-1:0]  push_pc,
  input  logic                  pop,
  input  logic                  flush,
  output logic [1:0]            count,
  output logic                  head_valid,
  output logic [InstrWidth-1:0] head_instr,
  output logic [AddrWidth-1:0]  head_pc
);

  logic [1:0]            count_q, count_d;
  logic [InstrWidth-1:0] ent0_instr_q, ent0_instr_d, ent1_instr_q, ent1_instr_d;
  logic [AddrWidth-1:0]  ent0_pc_q, ent0_pc_d, ent1_pc_q, ent1_pc_d;

  // Next-state: flush wins; otherwise shift on pop and fill the first free slot on push.
  always_comb begin
    count_d      = count_q;
    ent0_instr_d = ent0_instr_q;
    ent0_pc_d    = ent0_pc_q;
    ent1_instr_d = ent1_instr_q;
    ent1_pc_d    = ent1_pc_q;
    if (flush) begin
      count_d      = 2'd0;
      ent0_instr_d = NopInstr;
      ent0_pc_d    = '0;
      ent1_instr_d = NopInstr;
      ent1_pc_d    = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_instr_d = push_instr;
            ent0_pc_d    = push_pc;
          end else begin
            ent1_instr_d = push_instr;
            ent1_pc_d    = push_pc;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_instr_d = ent1_instr_q;
          ent0_pc_d    = ent1_pc_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous enqueue/dequeue keeps the occupancy unchanged.
          if (count_q == 2'd2) begin
            ent0_instr_d = ent1_instr_q;
            ent0_pc_d    = ent1_pc_q;
            ent1_instr_d = push_instr;
            ent1_pc_d    = push_pc;
          end else begin
            ent0_instr_d = push_instr;
            ent0_pc_d    = push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      ent0_instr_q <= NopInstr;
      ent0_pc_q    <= '0;
      ent1_instr_q <= NopInstr;
      ent1_pc_q    <= '0;
    end else begin
      count_q      <= count_d;
      ent0_instr_q <= ent0_instr_d;
      ent0_pc_q    <= ent0_pc_d;
      ent1_instr_q <= ent1_instr_d;
      ent1_pc_q    <= ent1_pc_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_instr = ent0_instr_q;
  assign head_pc    = ent0_pc_q;

  // The issue throttle guarantees a full queue is never written without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count_q == 2'd2))
    else $error("fetch_queue: push into full queue");

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && count_q == 2'd0))
    else $error("fetch_queue: pop from empty queue");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, BOOT/RUN FSM, one in-flight fetch to a
// registered instruction memory, and a 2-entry queue toward decode.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt / squash_cnt outputs.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [AddrWidth-1:0]  redirect_pc,
  output logic [AddrWidth-1:0]  imem_addr,
  input  logic [InstrWidth-1:0] imem_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [InstrWidth-1:0] if_instr,
  output logic [AddrWidth-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]           fetch_cnt,
  output logic [15:0]           squash_cnt
`endif
);

  fetch_state_e         state_q;
  logic [AddrWidth-1:0] pc_q;
  logic                 inflight_q;
  logic [AddrWidth-1:0] inflight_pc_q;

  logic [1:0] q_count;
  logic       deq_fire;
  logic       redirect_fire;
  logic       issue_fire;
  logic [2:0] occupancy;

  assign deq_fire      = if_valid && if_ready;
  assign redirect_fire = redirect_valid && (state_q == StRun);
  assign occupancy     = {1'b0, q_count} + {2'b0, inflight_q};
  // Issue only if the result is guaranteed a queue slot when it lands.
  assign issue_fire    = (state_q == StRun) && !redirect_fire &&
                         (occupancy < (3'd2 + {2'b0, deq_fire}));

  assign imem_addr = pc_q;

  // FSM, PC and in-flight tracking; a redirect drops the in-flight fetch by not reissuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      unique case (state_q)
        StBoot:  state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StBoot;
      endcase
      if (redirect_fire) begin
        pc_q <= redirect_pc;
      end else if (issue_fire) begin
        pc_q <= pc_q + 8'd1;
      end
      inflight_q <= issue_fire;
      if (issue_fire) begin
        inflight_pc_q <= pc_q;
      end
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q && !redirect_fire),
    .push_instr (imem_data),
    .push_pc    (inflight_pc_q),
    .pop        (deq_fire),
    .flush      (redirect_fire),
    .count      (q_count),
    .head_valid (if_valid),
    .head_instr (if_instr),
    .head_pc    (if_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, squash_cnt_q;
  logic [2:0]  squash_amt;

  // A head consumed in the redirect cycle is a delivered fetch, not a squash.
  assign squash_amt = occupancy - {2'b0, deq_fire};

  // Saturating delivered/squashed instruction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 16'h0;
      squash_cnt_q <= 16'h0;
    end else begin
      if (deq_fire) begin
        fetch_cnt_q <= sat_add16(fetch_cnt_q, 3'd1);
      end
      if (redirect_fire) begin
        squash_cnt_q <= sat_add16(squash_cnt_q, squash_amt);
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued by the stimulus
// thread and popped by a monitor on every accepted head.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] squash_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  int base  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .squash_cnt     (squash_cnt)
`endif
  );

  // Registered-read memory holding instruction word a at address a.
  always @(posedge clk) imem_data <= {24'h0, imem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_from(input logic [7:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 8'(i));
  endtask

  // Monitor: every accepted head must be the next expected PC with instr == PC.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got if_pc %h, expected no output", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", 32'(if_pc), 32'(e));
        chk("sb_instr", if_instr, {24'h0, e});
        n_pop++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    #2;
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", 32'(if_pc), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset release, streaming with if_ready high: c0 is BOOT.
    expect_from(8'h00, 64);
    base  = n_pop;
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_addr", 32'(imem_addr), 32'h0);
    chk("boot_valid", 32'(if_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("c1_addr", 32'(imem_addr), 32'h0);
    chk("c1_valid", 32'(if_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("c2_addr", 32'(imem_addr), 32'h1);
    chk("c2_valid", 32'(if_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("c3_valid", 32'(if_valid), 32'h1);
    chk("c3_pc", 32'(if_pc), 32'h0);
    chk("c3_addr", 32'(imem_addr), 32'h2);
    repeat (9) cyc();
    chk("a_pops", 32'(n_pop - base), 32'd9);

    // Stall 5 cycles: head 09 holds, PC parks at 0B.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(if_valid), 32'h1);
      chk("stall_pc", 32'(if_pc), 32'h09);
      chk("stall_addr", 32'(imem_addr), 32'h0B);
      cyc();
    end
    if_ready = 1'b1;
    base     = n_pop;
    repeat (8) cyc();
    chk("b_pops", 32'(n_pop - base), 32'd8);

    // Fill the queue, then redirect to 0E while full.
    if_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h0E;
    @(negedge clk);
    chk("full_addr", 32'(imem_addr), 32'h13);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_pre", 32'(fetch_cnt), 32'd17);
`endif
    cyc();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    expect_from(8'h0E, 64);
    base = n_pop;
    @(negedge clk);
    chk("redir_addr", 32'(imem_addr), 32'h0E);
    chk("redir_flush", 32'(if_valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("squash_full", 32'(squash_cnt), 32'd2);
`endif
    cyc();
    @(negedge clk);
    chk("redir_valid1", 32'(if_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("redir_head", 32'(if_pc), 32'h0E);
    repeat (6) cyc();
    chk("c_pops", 32'(n_pop - base), 32'd6);

    // Redirect to FE coinciding with a dequeue of head 14, then PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    cyc();
    redirect_valid = 1'b0;
    expect_from(8'hFE, 64);
    base = n_pop;
    @(negedge clk);
    chk("wrap_addr", 32'(imem_addr), 32'hFE);
    chk("wrap_flush", 32'(if_valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_coinc", 32'(fetch_cnt), 32'd24);
    chk("squash_coinc", 32'(squash_cnt), 32'd3);
`endif
    cyc();
    cyc();
    @(negedge clk);
    chk("wrap_head", 32'(if_pc), 32'hFE);
    repeat (6) cyc();
    chk("d_pops", 32'(n_pop - base), 32'd6);

    // Reset mid-stream: outputs clear asynchronously, sequence restarts at 00.
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(if_valid), 32'h0);
    chk("mrst_instr", if_instr, 32'h0);
    chk("mrst_pc", 32'(if_pc), 32'h0);
    chk("mrst_addr", 32'(imem_addr), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_fetch_cnt", 32'(fetch_cnt), 32'h0);
    chk("mrst_squash_cnt", 32'(squash_cnt), 32'h0);
`endif
    repeat (2) cyc();
    expect_from(8'h00, 64);
    base  = n_pop;
    rst_n = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst2_valid", 32'(if_valid), 32'h1);
    chk("rst2_pc", 32'(if_pc), 32'h0);
    repeat (5) cyc();
    chk("f_pops", 32'(n_pop - base), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
